pc_pipeline_unit: RTL and testbench

- Parametrised program counter plus pipeline PC-shadow chain for the in-order pipeline.
- Generates the fetch PC and carries each instruction's return address (PC+INC) with a valid bit through STAGES pipeline registers.
- Handles stall bubbles, taken-flow-change redirect with flush of younger stages, and halt with pipeline drain.
- Sits between the hazard/branch logic and instruction memory; stage outputs feed the link-register and branch-target paths.

---
 rtl/pc_pipeline_unit_pkg.sv | 14 +
 rtl/pc_pipeline_unit_shadow_stage.sv | 46 ++++
 rtl/pc_pipeline_unit.sv | 140 ++++++++++++++
 tb/tb_pc_pipeline_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pipeline_unit_pkg.sv
// Shared definitions for the program counter and its PC-shadow chain.
package pc_pipeline_unit_pkg;

    // Control FSM encoding: normal flow, drain after halt, frozen after drain.
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } pc_state_e;

    localparam int          DEFAULT_ADDR_W   = 16;
    localparam int unsigned DEFAULT_RESET_PC = 32'd0;

endpackage

// File: rtl/pc_pipeline_unit_shadow_stage.sv
// One PC-shadow stage: return-address payload plus valid bit.
// hold keeps the contents, bubble loads the payload but clears valid,
// shift loads payload and valid from the upstream source.
module pc_shadow_stage
    import pc_pipeline_unit_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              bubble,
    input  logic              shift,
    input  logic [ADDR_W-1:0] d_pay,
    input  logic              d_vld,
    output logic [ADDR_W-1:0] q_pay,
    output logic              q_vld
);

    logic [ADDR_W-1:0] pay_r;
    logic              vld_r;

    // Stage register: hold has priority, then bubble, then a normal shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_r <= '0;
            vld_r <= 1'b0;
        end else if (hold) begin
            pay_r <= pay_r;
            vld_r <= vld_r;
        end else if (bubble) begin
            pay_r <= d_pay;
            vld_r <= 1'b0;
        end else if (shift) begin
            pay_r <= d_pay;
            vld_r <= d_vld;
        end else begin
            pay_r <= pay_r;
            vld_r <= vld_r;
        end
    end

    assign q_pay = pay_r;
    assign q_vld = vld_r;

endmodule

// File: rtl/pc_pipeline_unit.sv
// Fetch program counter plus a chain of return-address shadow stages.
// Handles stall bubbles, redirect with flush of younger stages, and a
// halt that drains the chain before freezing everything.
module pc_pipeline_unit
    import pc_pipeline_unit_pkg::*;
#(
    parameter int          ADDR_W         = DEFAULT_ADDR_W,
    parameter int          STAGES         = 3,
    parameter int          REDIRECT_STAGE = 1,
    parameter int unsigned RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned INC            = 32'd1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     flow_change,
    input  logic [ADDR_W-1:0]        dst,
    input  logic                     halt,
    output logic [ADDR_W-1:0]        pc,
    output logic [STAGES*ADDR_W-1:0] pc_stage,
    output logic [STAGES-1:0]        vld_stage,
    output logic                     halted
);

    pc_state_e         state_r;
    pc_state_e         state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              halted_r;
    logic [STAGES-1:0] hold_s;
    logic [STAGES-1:0] bubble_s;
    logic [STAGES-1:0] shift_s;
    logic [STAGES-1:0] vld_s;
    logic [ADDR_W-1:0] pay_s [STAGES];

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_inc_s = pc_r + ADDR_W'(INC);

    // Next-state, next-PC and per-stage controls from the registered state.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        hold_s       = '0;
        bubble_s     = '0;
        shift_s      = '0;
        case (state_r)
            ST_RUN: begin
                shift_s = '1;
                if (flow_change) begin
                    // Redirect wins over stall and halt; squash younger stages.
                    pc_next_s = dst;
                    for (int i = 0; i < STAGES; i++) begin
                        bubble_s[i] = (i <= REDIRECT_STAGE);
                    end
                end else if (stall) begin
                    // Stage 0 re-presents its instruction; stage 1 gets a bubble.
                    hold_s[0]   = 1'b1;
                    bubble_s[1] = 1'b1;
                end else if (halt) begin
                    bubble_s[0]  = 1'b1;
                    state_next_s = ST_DRAIN;
                end else begin
                    pc_next_s = pc_inc_s;
                end
            end
            ST_DRAIN: begin
                shift_s     = '1;
                bubble_s[0] = 1'b1;
                if (flow_change) begin
                    // An older instruction redirected, so the halt never happened.
                    pc_next_s = dst;
                    for (int i = 0; i < STAGES; i++) begin
                        bubble_s[i] = (i <= REDIRECT_STAGE);
                    end
                    state_next_s = ST_RUN;
                end else if (vld_s == '0) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                hold_s = '1;
            end
            default: begin
                // Unreachable encoding: freeze the chain and resume normal flow.
                hold_s       = '1;
                state_next_s = ST_RUN;
            end
        endcase
    end

    // PC, FSM state and halted flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            pc_r     <= ADDR_W'(RESET_PC);
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            halted_r <= (state_next_s == ST_HALTED);
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [ADDR_W-1:0] d_pay_s;
        logic              d_vld_s;

        if (g == 0) begin : g_first
            assign d_pay_s = pc_inc_s;
            assign d_vld_s = 1'b1;
        end else begin : g_rest
            assign d_pay_s = pay_s[g-1];
            assign d_vld_s = vld_s[g-1];
        end

        pc_shadow_stage #(
            .ADDR_W (ADDR_W)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .hold   (hold_s[g]),
            .bubble (bubble_s[g]),
            .shift  (shift_s[g]),
            .d_pay  (d_pay_s),
            .d_vld  (d_vld_s),
            .q_pay  (pay_s[g]),
            .q_vld  (vld_s[g])
        );

        assign pc_stage[g*ADDR_W +: ADDR_W] = pay_s[g];
    end

    assign pc        = pc_r;
    assign vld_stage = vld_s;
    assign halted    = halted_r;

endmodule

// File: tb/tb_pc_pipeline_unit.sv
// Self-checking bench for pc_pipeline_unit: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pc_pipeline_unit;

    localparam int RS = 1;  // redirect stage of the default instance

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flow_change, halt;
    logic [15:0] dst;
    logic [15:0] pc;
    logic [47:0] pc_stage;
    logic [2:0]  vld_stage;
    logic        halted;

    logic [7:0]  pc8;
    logic [23:0] pc_stage8;
    logic [2:0]  vld8;
    logic        halted8;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: fetch PC, per-stage payload/valid, mode 0=run 1=drain 2=halted
    logic [15:0] m_pc;
    logic [15:0] m_pay [3];
    logic        m_vld [3];
    int          m_mode;

    always #5 clk = ~clk;

    pc_pipeline_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flow_change (flow_change),
        .dst         (dst),
        .halt        (halt),
        .pc          (pc),
        .pc_stage    (pc_stage),
        .vld_stage   (vld_stage),
        .halted      (halted)
    );

    pc_pipeline_unit #(
        .ADDR_W   (8),
        .RESET_PC (32'hFE)
    ) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (1'b0),
        .flow_change (1'b0),
        .dst         (8'h00),
        .halt        (1'b0),
        .pc          (pc8),
        .pc_stage    (pc_stage8),
        .vld_stage   (vld8),
        .halted      (halted8)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 16'h0000;
        m_mode = 0;
        for (int k = 0; k < 3; k++) begin
            m_pay[k] = 16'h0000;
            m_vld[k] = 1'b0;
        end
    endtask

    // One clock of the pipeline, written from the behavioural rules.
    task automatic model_step(input logic s, input logic f, input logic [15:0] d, input logic h);
        logic [15:0] np [3];
        logic        nv [3];
        if (m_mode == 2) return;
        np[0] = m_pc + 16'd1;
        nv[0] = 1'b0;
        for (int k = 1; k < 3; k++) begin
            np[k] = m_pay[k-1];
            nv[k] = m_vld[k-1];
        end
        if (f) begin
            for (int k = 0; k <= RS; k++) nv[k] = 1'b0;
            m_pc   = d;
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (!(m_vld[0] || m_vld[1] || m_vld[2])) m_mode = 2;
        end else if (s) begin
            np[0] = m_pay[0];
            nv[0] = m_vld[0];
            nv[1] = 1'b0;
        end else if (h) begin
            m_mode = 1;
        end else begin
            nv[0] = 1'b1;
            m_pc  = m_pc + 16'd1;
        end
        for (int k = 0; k < 3; k++) begin
            m_pay[k] = np[k];
            m_vld[k] = nv[k];
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, "_pc"}, 32'(pc), 32'(m_pc));
        check_val({tag, "_vld"}, 32'(vld_stage), {29'd0, m_vld[2], m_vld[1], m_vld[0]});
        for (int k = 0; k < 3; k++) begin
            if (m_vld[k]) check_val($sformatf("%s_pay%0d", tag, k), 32'(pc_stage[k*16 +: 16]), 32'(m_pay[k]));
        end
        check_val({tag, "_halted"}, 32'(halted), 32'(m_mode == 2));
    endtask

    // Drive inputs, let one edge happen, advance the model, compare.
    task automatic cycle(input string tag, input logic s, input logic f, input logic h, input logic [15:0] d);
        stall = s; flow_change = f; halt = h; dst = d;
        @(posedge clk);
        model_step(s, f, d, h);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        check_val({tag, "_pc8"}, 32'(pc8), 32'h0000_00FE);
        check_val({tag, "_vld8"}, 32'(vld8), 32'h0);
        #2;
        stall = 1'b0; flow_change = 1'b0; halt = 1'b0; dst = 16'h0000;
        rst_n = 1'b1;
    endtask

    initial begin
        stall = 1'b0; flow_change = 1'b0; halt = 1'b0; dst = 16'h0000;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        check_val("reset_pc8", 32'(pc8), 32'h0000_00FE);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running fetch; the 8-bit instance wraps FE -> FF -> 00.
        cycle("run1", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("wrap_ff", 32'(pc8), 32'h0000_00FF);
        cycle("run2", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("wrap_00", 32'(pc8), 32'h0000_0000);
        cycle("run3", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("fill_s0", 32'(pc_stage[15:0]), 32'd3);
        check_val("fill_s1", 32'(pc_stage[31:16]), 32'd2);
        check_val("fill_s2", 32'(pc_stage[47:32]), 32'd1);
        check_val("fill_vld", 32'(vld_stage), 32'h7);
        cycle("run4", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("run4_pc", 32'(pc), 32'd4);
        cycle("run5", 1'b0, 1'b0, 1'b0, 16'h0);

        // Single-cycle stall at pc=5.
        cycle("stall", 1'b1, 1'b0, 1'b0, 16'h0);
        check_val("stall_pc", 32'(pc), 32'd5);
        check_val("stall_s0", 32'(pc_stage[15:0]), 32'd5);
        check_val("stall_v1", 32'(vld_stage[1]), 32'd0);
        cycle("resume", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("resume_pc", 32'(pc), 32'd6);
        cycle("run7", 1'b0, 1'b0, 1'b0, 16'h0);
        cycle("run8", 1'b0, 1'b0, 1'b0, 16'h0);

        // Redirect at pc=8 with a simultaneous stall that must be ignored.
        cycle("redir", 1'b1, 1'b1, 1'b0, 16'h0040);
        check_val("redir_pc", 32'(pc), 32'h40);
        check_val("redir_vld", 32'(vld_stage), 32'h4);

        // Refill so the halt starts from a full chain at pc=0x10.
        cycle("redir2", 1'b0, 1'b1, 1'b0, 16'h000D);
        for (int i = 0; i < 3; i++) cycle("refill", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("refill_pc", 32'(pc), 32'h10);
        check_val("refill_vld", 32'(vld_stage), 32'h7);
        cycle("halt", 1'b0, 1'b0, 1'b1, 16'h0);
        check_val("halt_vld", 32'(vld_stage), 32'h6);
        cycle("drain1", 1'b1, 1'b0, 1'b0, 16'h0);
        check_val("drain1_vld", 32'(vld_stage), 32'h4);
        cycle("drain2", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("drain2_vld", 32'(vld_stage), 32'h0);
        check_val("drain2_halted", 32'(halted), 32'd0);
        cycle("halted", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("halted_flag", 32'(halted), 32'd1);
        cycle("halted_fc", 1'b1, 1'b1, 1'b1, 16'h0099);
        check_val("halted_pc", 32'(pc), 32'h10);

        async_reset("midrst");

        // Halt squashed by a redirect during drain.
        for (int i = 0; i < 3; i++) cycle("run", 1'b0, 1'b0, 1'b0, 16'h0);
        cycle("halt2", 1'b0, 1'b0, 1'b1, 16'h0);
        cycle("squash", 1'b0, 1'b1, 1'b0, 16'h0020);
        check_val("squash_pc", 32'(pc), 32'h20);
        check_val("squash_halted", 32'(halted), 32'd0);
        cycle("after_squash", 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("after_squash_pc", 32'(pc), 32'h21);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (m_mode == 2 && $urandom_range(3) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cycle("rnd",
                      ($urandom_range(4) == 0),
                      ($urandom_range(7) == 0),
                      ($urandom_range(15) == 0),
                      16'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
